// File: rtl/csd_conv_arbiter.sv
// Round-robin front end that time-shares a single binary-to-CSD converter among N clients.
// One job in flight: accept operand, pulse start, wait for done or timeout, return result to owner.
module csd_conv_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int RES_W   = 2*(W+1),
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*W-1:0]   req_operand,
  output logic [N-1:0]     rsp_valid,
  input  logic [N-1:0]     rsp_ready,
  output logic [RES_W-1:0] rsp_digits,
  output logic             rsp_err,
  output logic             conv_start,
  output logic [W-1:0]     conv_operand,
  input  logic             conv_done,
  input  logic [RES_W-1:0] conv_digits,
  output logic             busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t           r_state, w_state_next;
  logic [PW-1:0]    r_rr_ptr, r_owner, w_winner, w_next_ptr;
  logic             w_found, w_rsp_ack, w_timeout;
  logic [W-1:0]     r_operand;
  logic [RES_W-1:0] r_result;
  logic             r_err;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_scan_idx [N];
  logic [W-1:0]     w_req_op [N];

  // w_scan_idx[k] is the requester visited k-th, starting at r_rr_ptr
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [PW:0] w_sum;
    assign w_sum           = {1'b0, r_rr_ptr} + (PW+1)'(gi);
    assign w_scan_idx[gi]  = (w_sum >= (PW+1)'(N)) ? PW'(w_sum - (PW+1)'(N)) : PW'(w_sum);
    assign w_req_op[gi]    = req_operand[gi*W +: W];
    assign req_ready[gi]   = (r_state == S_IDLE) && w_found && (w_winner == PW'(gi));
    assign rsp_valid[gi]   = (r_state == S_RESP) && (r_owner == PW'(gi));
  end

  // Walk from the far end so the nearest valid requester overwrites the rest
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (req_valid[w_scan_idx[k]]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx[k];
      end
    end
  end

  assign w_rsp_ack  = rsp_ready[r_owner];
  assign w_timeout  = (r_count == CW'(TIMEOUT-1));
  assign w_next_ptr = (r_owner == PW'(N-1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_state_next = S_LAUNCH;
      S_LAUNCH: w_state_next = S_WAIT;
      S_WAIT:   if (conv_done || w_timeout) w_state_next = S_RESP;
      S_RESP:   if (w_rsp_ack) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_operand <= '0;
      r_result  <= '0;
      r_err     <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_operand <= w_req_op[w_winner];
            r_owner   <= w_winner;
          end
        end
        S_LAUNCH: r_count <= '0;
        S_WAIT: begin
          r_count <= r_count + 1'b1;
          // a completion arriving on the last allowed cycle still counts as success
          if (conv_done) begin
            r_result <= conv_digits;
            r_err    <= 1'b0;
          end else if (w_timeout) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
        S_RESP:   if (w_rsp_ack) r_rr_ptr <= w_next_ptr;
        default:  ;
      endcase
    end
  end

  assign conv_start   = (r_state == S_LAUNCH);
  assign busy         = (r_state != S_IDLE);
  assign conv_operand = r_operand;
  assign rsp_digits   = r_result;
  assign rsp_err      = r_err;

endmodule

// File: tb/tb_csd_conv_arbiter.sv
// Directed bench for csd_conv_arbiter: a cycle table for the basic job, then hand-written
// sequences for fairness, timeout, done-on-timeout, response back-pressure and mid-job reset.
module tb_csd_conv_arbiter;
  localparam int N = 4, W = 8, RES_W = 18, TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N*W-1:0]   req_operand = '0;
  logic [RES_W-1:0] rsp_digits, conv_digits = '0;
  logic             rsp_err, conv_start, conv_done = 1'b0, busy;
  logic [W-1:0]     conv_operand;

  int n_cmp = 0;
  int n_err = 0;

  csd_conv_arbiter #(.N(N), .W(W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_operand(req_operand),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_digits(rsp_digits), .rsp_err(rsp_err),
    .conv_start(conv_start), .conv_operand(conv_operand), .conv_done(conv_done),
    .conv_digits(conv_digits), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rv;
    logic [3:0]  rr;
    logic        cd;
    logic [17:0] cdig;
    logic [3:0]  e_rdy;
    logic [3:0]  e_rsp;
    logic        e_start;
    logic        e_busy;
    logic        chk_op;
    logic [7:0]  e_op;
    logic [17:0] e_dig;
    logic        e_err;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1; req_valid = '0; rsp_ready = '0; conv_done = 1'b0;
    conv_digits = '0; req_operand = '0;
    tick();
    tick();
    reset = 1'b0;
    smp();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_conv_start", conv_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_digits", rsp_digits, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_conv_operand", conv_operand, 0);
  endtask

  vec_t vt [12];
  int   order [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    // rv rr cd cdig | e_rdy e_rsp start busy chk_op op dig err
    vt[0]  = '{4'b0100, 4'b0000, 0, 18'h0,     4'b0100, 4'b0000, 0, 0, 0, 8'h00, 18'h0,     0};
    vt[1]  = '{4'b0000, 4'b0000, 0, 18'h0,     4'b0000, 4'b0000, 1, 1, 1, 8'h37, 18'h0,     0};
    vt[2]  = '{4'b0000, 4'b0000, 0, 18'h0,     4'b0000, 4'b0000, 0, 1, 1, 8'h37, 18'h0,     0};
    vt[3]  = '{4'b0000, 4'b0000, 0, 18'h0,     4'b0000, 4'b0000, 0, 1, 1, 8'h37, 18'h0,     0};
    vt[4]  = '{4'b0000, 4'b0000, 1, 18'h0A5A5, 4'b0000, 4'b0000, 0, 1, 1, 8'h37, 18'h0,     0};
    vt[5]  = '{4'b0000, 4'b0000, 0, 18'h0,     4'b0000, 4'b0100, 0, 1, 0, 8'h00, 18'h0A5A5, 0};
    vt[6]  = '{4'b0000, 4'b0100, 0, 18'h0,     4'b0000, 4'b0100, 0, 1, 0, 8'h00, 18'h0A5A5, 0};
    vt[7]  = '{4'b1111, 4'b0000, 0, 18'h0,     4'b1000, 4'b0000, 0, 0, 0, 8'h00, 18'h0,     0};
    vt[8]  = '{4'b0000, 4'b0000, 0, 18'h0,     4'b0000, 4'b0000, 1, 1, 1, 8'h44, 18'h0,     0};
    vt[9]  = '{4'b0000, 4'b0000, 1, 18'h3FFFF, 4'b0000, 4'b0000, 0, 1, 1, 8'h44, 18'h0,     0};
    vt[10] = '{4'b0000, 4'b1000, 0, 18'h0,     4'b0000, 4'b1000, 0, 1, 0, 8'h00, 18'h3FFFF, 0};
    vt[11] = '{4'b0011, 4'b0000, 0, 18'h0,     4'b0001, 4'b0000, 0, 0, 0, 8'h00, 18'h0,     0};

    // ---- basic job via cycle table ----
    do_reset();
    req_operand = 32'h4437_2211;
    for (int v = 0; v < 12; v++) begin
      tick();
      req_valid = vt[v].rv; rsp_ready = vt[v].rr;
      conv_done = vt[v].cd; conv_digits = vt[v].cdig;
      smp();
      chk($sformatf("t1_req_ready[%0d]", v), req_ready, vt[v].e_rdy);
      chk($sformatf("t1_rsp_valid[%0d]", v), rsp_valid, vt[v].e_rsp);
      chk($sformatf("t1_conv_start[%0d]", v), conv_start, vt[v].e_start);
      chk($sformatf("t1_busy[%0d]", v), busy, vt[v].e_busy);
      if (vt[v].chk_op) chk($sformatf("t1_conv_op[%0d]", v), conv_operand, vt[v].e_op);
      if (vt[v].e_rsp != 0) begin
        chk($sformatf("t1_digits[%0d]", v), rsp_digits, vt[v].e_dig);
        chk($sformatf("t1_err[%0d]", v), rsp_err, vt[v].e_err);
        $display("t1 vec %0d: rsp_valid=%b digits=%h err=%b", v, rsp_valid, rsp_digits, rsp_err);
      end
    end

    // ---- round-robin fairness with a zero-latency converter ----
    do_reset();
    begin
      int  g = 0;
      logic prev_start = 1'b0;
      for (int c = 0; c < 80 && g < 6; c++) begin
        tick();
        if (c == 0) begin
          req_valid = 4'b1011; rsp_ready = 4'b1111; req_operand = 32'h4433_2211;
        end
        conv_done = prev_start;
        smp();
        chk("rr_onehot", ($countones(req_ready) <= 1), 1);
        if (req_ready != 0) begin
          chk($sformatf("rr_grant%0d", g), req_ready, 32'(1) << order[g]);
          $display("rr grant %0d: req_ready=%b", g, req_ready);
          g++;
        end
        prev_start = conv_start;
      end
      chk("rr_grant_count", g, 6);
    end

    // ---- timeout, then a normal job ----
    do_reset();
    tick(); req_valid = 4'b0001; req_operand = 32'h0000_005A; conv_digits = 18'h12345; smp();
    chk("to_grant", req_ready, 4'b0001);
    tick(); req_valid = 4'b0000; smp();
    chk("to_start", conv_start, 1);
    chk("to_op", conv_operand, 8'h5A);
    begin
      int n = 0;
      for (int c = 0; c < 200; c++) begin
        tick(); smp();
        if (rsp_valid != 0) break;
        n++;
      end
      chk("to_wait_cycles", n, TIMEOUT);
    end
    chk("to_rsp_valid", rsp_valid, 4'b0001);
    chk("to_err", rsp_err, 1);
    chk("to_digits", rsp_digits, 0);
    $display("timeout rsp: rsp_valid=%b digits=%h err=%b", rsp_valid, rsp_digits, rsp_err);
    tick(); rsp_ready = 4'b0001; smp();
    tick(); rsp_ready = 4'b0000; req_valid = 4'b0011; req_operand = 32'h0000_C35A; smp();
    chk("to_next_idle", busy, 0);
    chk("to_next_grant", req_ready, 4'b0010);
    tick(); req_valid = 4'b0000; smp();
    chk("to_next_op", conv_operand, 8'hC3);
    tick(); conv_done = 1'b1; conv_digits = 18'h2AAAA; smp();
    tick(); conv_done = 1'b0; rsp_ready = 4'b0010; smp();
    chk("to_next_rsp", rsp_valid, 4'b0010);
    chk("to_next_digits", rsp_digits, 18'h2AAAA);
    chk("to_next_err", rsp_err, 0);

    // ---- conv_done on the final timeout cycle ----
    do_reset();
    tick(); req_valid = 4'b0100; req_operand = 32'h0077_0000; conv_digits = 18'h1B00D; smp();
    chk("dt_grant", req_ready, 4'b0100);
    tick(); req_valid = 4'b0000; smp();
    chk("dt_start", conv_start, 1);
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick(); conv_done = (i == TIMEOUT); smp();
      if (i >= TIMEOUT-1) chk($sformatf("dt_wait%0d", i), rsp_valid, 0);
    end
    tick(); conv_done = 1'b0; smp();
    chk("dt_rsp", rsp_valid, 4'b0100);
    chk("dt_err", rsp_err, 0);
    chk("dt_digits", rsp_digits, 18'h1B00D);

    // ---- response back-pressure ----
    do_reset();
    tick(); req_valid = 4'b0010; req_operand = 32'h0088_9900; smp();
    chk("bp_grant", req_ready, 4'b0010);
    tick(); req_valid = 4'b0000; smp();
    chk("bp_op", conv_operand, 8'h99);
    tick(); conv_done = 1'b1; conv_digits = 18'h15555; smp();
    tick(); conv_done = 1'b0; conv_digits = 18'h0; req_valid = 4'b1111; rsp_ready = 4'b1101; smp();
    for (int i = 0; i < 10; i++) begin
      tick(); smp();
      chk("bp_hold_valid", rsp_valid, 4'b0010);
      chk("bp_hold_digits", rsp_digits, 18'h15555);
      chk("bp_hold_ready", req_ready, 0);
    end
    tick(); rsp_ready = 4'b0010; smp();
    chk("bp_last_valid", rsp_valid, 4'b0010);
    tick(); rsp_ready = 4'b0000; smp();
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_rsp", rsp_valid, 0);
    chk("bp_idle_grant", req_ready, 4'b0100);

    // ---- reset in WAIT, then a stray done ----
    tick(); req_valid = 4'b0000; smp();
    chk("mr_start", conv_start, 1);
    chk("mr_op", conv_operand, 8'h88);
    tick(); smp();
    chk("mr_wait_busy", busy, 1);
    tick(); reset = 1'b1; smp();
    tick(); reset = 1'b0; smp();
    chk("mr_busy", busy, 0);
    chk("mr_rsp", rsp_valid, 0);
    chk("mr_start0", conv_start, 0);
    chk("mr_op0", conv_operand, 0);
    chk("mr_digits", rsp_digits, 0);
    chk("mr_err", rsp_err, 0);
    tick(); conv_done = 1'b1; conv_digits = 18'h3FFFF; smp();
    chk("mr_stray_busy", busy, 0);
    tick(); conv_done = 1'b0; smp();
    chk("mr_stray_rsp", rsp_valid, 0);
    chk("mr_stray_busy2", busy, 0);
    tick(); req_valid = 4'b1111; smp();
    chk("mr_rr_ptr", req_ready, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
